// File: rtl/traffic_injector_if.sv
// Valid/ready flit channel between the traffic injector and its downstream consumer.
interface traffic_injector_if #(
    parameter int DW = 32
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/traffic_injector.sv
// Flit source: emits TOTAL_FLITS tagged flits as fixed-length packets, with a
// programmable idle gap after each packet, then parks in DONE until reset.
module traffic_injector #(
    parameter int DW          = 32,
    parameter int PKT_LEN     = 4,
    parameter int GAP         = 2,
    parameter int TOTAL_FLITS = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    traffic_injector_if.master        bus,
    output logic                      done,
    output logic [31:0]               flit_cnt
);

    localparam int          PW       = DW - 18;
    localparam logic [7:0]  LAST_IDX = 8'(PKT_LEN - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP - 1);
    localparam logic [31:0] TOTAL    = 32'(TOTAL_FLITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] pkt_id;
    logic [PW-1:0] pkt_id_nxt;
    logic [7:0]    idx;
    logic [7:0]    idx_nxt;
    logic [7:0]    gap_cnt;
    logic [7:0]    gap_cnt_nxt;
    logic [31:0]   cnt_nxt;
    logic          xfer;
    logic          pkt_last;
    logic          head;
    logic          tail;
    logic [DW-1:0] data_nxt;

    assign xfer     = (state == S_SEND) && bus.ready;
    assign pkt_last = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    if (cnt_nxt == TOTAL) begin
                        state_nxt = S_DONE;
                    end else if (pkt_last && (GAP > 0)) begin
                        state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = S_SEND;
                end
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // The flit is built from post-transfer counters so the register already
    // holds the next flit when valid rises or the previous one is accepted.
    always_comb begin
        cnt_nxt     = flit_cnt + 32'(xfer);
        idx_nxt     = idx;
        pkt_id_nxt  = pkt_id;
        gap_cnt_nxt = 8'd0;
        if (xfer) begin
            if (pkt_last) begin
                idx_nxt    = 8'd0;
                pkt_id_nxt = pkt_id + PW'(1);
            end else begin
                idx_nxt = idx + 8'd1;
            end
        end
        if ((state == S_GAP) && (gap_cnt != GAP_LAST)) begin
            gap_cnt_nxt = gap_cnt + 8'd1;
        end
        head     = (idx_nxt == 8'd0);
        tail     = (idx_nxt == LAST_IDX) || (cnt_nxt == TOTAL - 32'd1);
        data_nxt = {tail, head, pkt_id_nxt, cnt_nxt[15:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.valid <= 1'b0;
            bus.data  <= '0;
            done      <= 1'b0;
            flit_cnt  <= 32'd0;
            pkt_id    <= '0;
            idx       <= 8'd0;
            gap_cnt   <= 8'd0;
        end else begin
            bus.valid <= (state_nxt == S_SEND);
            done      <= (state_nxt == S_DONE);
            flit_cnt  <= cnt_nxt;
            pkt_id    <= pkt_id_nxt;
            idx       <= idx_nxt;
            gap_cnt   <= gap_cnt_nxt;
            if (state_nxt == S_SEND) begin
                bus.data <= data_nxt;
            end
        end
    end

endmodule

// File: tb/tb_traffic_injector.sv
// Directed bench for traffic_injector: default run, backpressure, single-flit
// packets, truncated streams, mid-packet reset and ignored start pulses.
module tb_traffic_injector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        startA = 1'b0;
    logic        startB = 1'b0;
    logic        startC = 1'b0;
    logic        startD = 1'b0;
    logic        readyA = 1'b1;
    logic        doneA, doneB, doneC, doneD;
    logic [31:0] cntA, cntB, cntC, cntD;
    int          checks = 0;
    int          errors = 0;

    traffic_injector_if #(.DW(32)) busA ();
    traffic_injector_if #(.DW(32)) busB ();
    traffic_injector_if #(.DW(32)) busC ();
    traffic_injector_if #(.DW(20)) busD ();

    assign busA.ready = readyA;
    assign busB.ready = 1'b1;
    assign busC.ready = 1'b1;
    assign busD.ready = 1'b1;

    traffic_injector #(.DW(32), .PKT_LEN(4), .GAP(2), .TOTAL_FLITS(1024)) dutA (
        .clk(clk), .rst(rst), .start(startA), .bus(busA), .done(doneA), .flit_cnt(cntA)
    );
    traffic_injector #(.DW(32), .PKT_LEN(1), .GAP(0), .TOTAL_FLITS(8)) dutB (
        .clk(clk), .rst(rst), .start(startB), .bus(busB), .done(doneB), .flit_cnt(cntB)
    );
    traffic_injector #(.DW(32), .PKT_LEN(4), .GAP(0), .TOTAL_FLITS(10)) dutC (
        .clk(clk), .rst(rst), .start(startC), .bus(busC), .done(doneC), .flit_cnt(cntC)
    );
    traffic_injector #(.DW(20), .PKT_LEN(4), .GAP(1), .TOTAL_FLITS(9)) dutD (
        .clk(clk), .rst(rst), .start(startD), .bus(busD), .done(doneD), .flit_cnt(cntD)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic doReset, input logic [3:0] starts);
        rst    = doReset;
        startA = starts[0];
        startB = starts[1];
        startC = starts[2];
        startD = starts[3];
        @(negedge clk);
        rst    = 1'b0;
        startA = 1'b0;
        startB = 1'b0;
        startC = 1'b0;
        startD = 1'b0;
    endtask

    // Expected flit of the default configuration for global index n.
    function automatic logic [31:0] expFlit(input int n);
        int         k = n % 4;
        logic [1:0] t;
        t = {(k == 3) || (n == 1023), (k == 0)};
        return {t, 14'(n / 4), 16'(n)};
    endfunction

    logic [31:0] cExp [10] = '{32'h40000000, 32'h00000001, 32'h00000002, 32'h80000003,
                               32'h40010004, 32'h00010005, 32'h00010006, 32'h80010007,
                               32'h40020008, 32'h80020009};
    logic [19:0] dExp [9]  = '{20'h40000, 20'h00001, 20'h00002, 20'h80003,
                               20'h50004, 20'h10005, 20'h10006, 20'h90007, 20'hE0008};

    initial begin
        int          n;
        int          cyc;
        logic        pstall;
        logic [31:0] pdata;
        logic        found;

        rst = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 4'b0000);
        checkOutput("rst_valid", 32'(busA.valid), 32'd0);
        checkOutput("rst_data", busA.data, 32'd0);
        checkOutput("rst_done", 32'(doneA), 32'd0);
        checkOutput("rst_cnt", cntA, 32'd0);

        // Default run with start pulses injected during SEND and GAP.
        applyStimulus(1'b0, 4'b0001);
        for (int i = 0; i < 1024; i++) begin
            checkOutput("def_valid", 32'(busA.valid), 32'd1);
            checkOutput("def_data", busA.data, expFlit(i));
            checkOutput("def_cnt", cntA, 32'(i));
            startA = (i == 5);
            @(negedge clk);
            startA = 1'b0;
            if ((i % 4 == 3) && (i != 1023)) begin
                for (int g = 0; g < 2; g++) begin
                    checkOutput("def_gap", 32'(busA.valid), 32'd0);
                    startA = (i == 43) && (g == 0);
                    @(negedge clk);
                    startA = 1'b0;
                end
            end
        end
        checkOutput("def_done", 32'(doneA), 32'd1);
        checkOutput("def_end_valid", 32'(busA.valid), 32'd0);
        checkOutput("def_end_cnt", cntA, 32'd1024);
        applyStimulus(1'b0, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            checkOutput("ign_done", 32'(doneA), 32'd1);
            checkOutput("ign_valid", 32'(busA.valid), 32'd0);
            checkOutput("ign_cnt", cntA, 32'd1024);
            @(negedge clk);
        end

        // Backpressure: ready low roughly 30% of cycles.
        applyStimulus(1'b1, 4'b0000);
        n      = 0;
        cyc    = 0;
        pstall = 1'b0;
        pdata  = 32'd0;
        readyA = 1'b1;
        applyStimulus(1'b0, 4'b0001);
        while (!doneA && cyc < 5000) begin
            if (pstall) begin
                checkOutput("bp_hold", 32'(busA.valid), 32'd1);
                checkOutput("bp_stable", busA.data, pdata);
            end
            if (busA.valid) begin
                checkOutput("bp_data", busA.data, expFlit(n));
                checkOutput("bp_cnt", cntA, 32'(n));
            end
            readyA = ($urandom_range(0, 9) >= 3);
            pstall = busA.valid && !readyA;
            pdata  = busA.data;
            if (busA.valid && readyA) begin
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput("bp_timeout", 32'(cyc < 5000), 32'd1);
        checkOutput("bp_total", 32'(n), 32'd1024);
        checkOutput("bp_end_cnt", cntA, 32'd1024);
        readyA = 1'b1;

        // Reset while flit 2 of packet 5 is stalled.
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0001);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (busA.valid && busA.data[15:0] == 16'd22) begin
                readyA = 1'b0;
                found  = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        checkOutput("mr_found", 32'(found), 32'd1);
        checkOutput("mr_flit", busA.data, 32'h00050016);
        @(negedge clk);
        checkOutput("mr_stall_valid", 32'(busA.valid), 32'd1);
        checkOutput("mr_stall_data", busA.data, 32'h00050016);
        checkOutput("mr_stall_cnt", cntA, 32'd22);
        applyStimulus(1'b1, 4'b0000);
        checkOutput("mr_valid", 32'(busA.valid), 32'd0);
        checkOutput("mr_cnt", cntA, 32'd0);
        checkOutput("mr_data", busA.data, 32'd0);
        checkOutput("mr_done", 32'(doneA), 32'd0);
        applyStimulus(1'b0, 4'b0001);
        checkOutput("mr_restart_valid", 32'(busA.valid), 32'd1);
        checkOutput("mr_restart_data", busA.data, 32'h40000000);
        checkOutput("mr_restart_cnt", cntA, 32'd0);

        // Single-flit packets, back to back.
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0010);
        for (int i = 0; i < 8; i++) begin
            checkOutput("sf_valid", 32'(busB.valid), 32'd1);
            checkOutput("sf_data", busB.data, {2'b11, 14'(i), 16'(i)});
            checkOutput("sf_cnt", cntB, 32'(i));
            @(negedge clk);
        end
        checkOutput("sf_done", 32'(doneB), 32'd1);
        checkOutput("sf_end_valid", 32'(busB.valid), 32'd0);
        checkOutput("sf_end_cnt", cntB, 32'd8);

        // Truncated stream of 10 flits, no gap.
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0100);
        for (int i = 0; i < 10; i++) begin
            checkOutput("tr10_valid", 32'(busC.valid), 32'd1);
            checkOutput("tr10_data", busC.data, cExp[i]);
            @(negedge clk);
        end
        checkOutput("tr10_done", 32'(doneC), 32'd1);
        checkOutput("tr10_cnt", cntC, 32'd10);

        // Truncated stream of 9 flits on a 20-bit bus with a one-cycle gap.
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b1000);
        for (int i = 0; i < 9; i++) begin
            if (i == 4 || i == 8) begin
                checkOutput("tr9_gap", 32'(busD.valid), 32'd0);
                @(negedge clk);
            end
            checkOutput("tr9_valid", 32'(busD.valid), 32'd1);
            checkOutput("tr9_data", 32'(busD.data), 32'(dExp[i]));
            @(negedge clk);
        end
        checkOutput("tr9_done", 32'(doneD), 32'd1);
        checkOutput("tr9_end_valid", 32'(busD.valid), 32'd0);
        checkOutput("tr9_cnt", cntD, 32'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
